// File: rtl/lc4_div_iter.sv
// lc4_div_iter: iterative restoring unsigned divider producing quotient and remainder,
// one quotient bit per cycle behind a valid/ready handshake.
module lc4_div_iter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam int CW = $clog2(W);

    logic [1:0]    state;
    logic [W-1:0]  dvd, dsr, rem, q, rem_n, q_n;
    logic [CW-1:0] cnt;
    logic [W:0]    t;

    // A negative trial difference means the divisor did not fit: restore and shift in 0.
    always_comb begin
        t     = {rem, dvd[W-1]} - {1'b0, dsr};
        rem_n = t[W] ? {rem[W-2:0], dvd[W-1]} : t[W-1:0];
        q_n   = {q[W-2:0], ~t[W]};
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dvd   <= dividend;
                    dsr   <= divisor;
                    rem   <= '0;
                    q     <= '0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    rem <= rem_n;
                    q   <= q_n;
                    dvd <= {dvd[W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        // Divide by zero still runs all iterations, then reports 0/0.
                        quotient  <= (dsr == '0) ? '0 : q_n;
                        remainder <= (dsr == '0) ? '0 : rem_n;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc4_div_iter.sv
// tb_lc4_div_iter: directed vector table, back-pressure, async reset and random sweep
// against an arithmetic reference for lc4_div_iter.
module tb_lc4_div_iter;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [15:0] dividend = 0, divisor = 0;
    logic        in_ready, out_valid, busy;
    logic [15:0] quotient, remainder;
    int checks = 0, failures = 0;

    lc4_div_iter #(.W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b, eq, er;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present operands at a negedge, accepted at the next posedge (E0).
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1; dividend = a; divisor = b;
        @(posedge clk); #1;
        in_valid = 0; dividend = ~a; divisor = ~b;
    endtask

    // Wait for out_valid, returning the edge count after E0; optionally toggle in_valid in RUN.
    task automatic wait_done(input bit toggle, output int cyc);
        bit hs_bad = 0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready || !busy) hs_bad = 1;
            if (toggle) in_valid = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 0;
        chk("ready_busy_during_run", {31'd0, hs_bad}, 0);
        chk("latency", cyc, 16);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("post_consume_out_valid", out_valid, 0);
        chk("post_consume_in_ready", in_ready, 1);
    endtask

    task automatic do_op(input logic [15:0] a, b, eq, er);
        int cyc;
        start_op(a, b);
        wait_done(0, cyc);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        consume();
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [15:0] a, b, eq, er;
        vecs[0] = '{16'd100, 16'd7, 16'd14, 16'd2};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000};
        vecs[2] = '{16'h0003, 16'h000A, 16'h0000, 16'h0003};
        vecs[3] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h8000};
        vecs[4] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[6] = '{16'h0000, 16'h0005, 16'h0000, 16'h0000};
        vecs[7] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        vecs[8] = '{16'd65535, 16'd256, 16'd255, 16'd255};

        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er);

        // Back-pressure: result must hold while out_ready stays low.
        start_op(16'd200, 16'd9);
        wait_done(0, cyc);
        repeat (5) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_quotient", quotient, 22);
            chk("bp_remainder", remainder, 2);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        consume();
        do_op(16'd50, 16'd5, 16'd10, 16'd0);

        // Asynchronous reset mid-RUN discards the operation.
        start_op(16'd1000, 16'd3);
        repeat (7) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("arst_no_out_valid", {31'd0, seen}, 0);
        do_op(16'd1000, 16'd3, 16'd333, 16'd1);

        // Random sweep with back-pressure and in_valid noise during RUN.
        for (int n = 0; n < 300; n++) begin
            a = 16'($urandom);
            b = (n % 10 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            if (n % 3 == 0) b = b >> $urandom_range(0, 15);
            eq = (b == 0) ? 16'd0 : a / b;
            er = (b == 0) ? 16'd0 : a % b;
            start_op(a, b);
            wait_done(1, cyc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk("rnd_out_valid_held", out_valid, 1);
            chk("rnd_quotient", quotient, eq);
            chk("rnd_remainder", remainder, er);
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
